// File: rtl/cpu_io_pkg.sv
// Shared register map and address helpers for the cpu I/O bank.
package cpu_io_pkg;

  localparam logic [1:0] IO_REG_IN   = 2'd0;
  localparam logic [1:0] IO_REG_OUT  = 2'd1;
  localparam logic [1:0] IO_REG_CHG  = 2'd2;
  localparam logic [1:0] IO_REG_MASK = 2'd3;

  // CSR address width: channel index bits plus two register-select bits,
  // never narrower than 3 so a single-channel bank still decodes an index.
  function automatic int io_addr_w(input int n_ch);
    int cw;
    cw = 0;
    for (int i = 0; i < 5; i++) begin
      if ((32'sd1 << i) < n_ch) begin
        cw = i + 1;
      end else begin
        cw = cw;
      end
    end
    if ((cw + 2) < 3) begin
      return 3;
    end else begin
      return cw + 2;
    end
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Multi-stage input synchroniser followed by a sample register; reports the
// synchronised value and the bits that changed since the previous cycle.
module io_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] sync_last,
  output logic [WIDTH-1:0] delta
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]                  samp_q;
  logic [WIDTH-1:0]                  samp_d;

  // Shift the raw input through the synchroniser chain and resample its tail.
  always_comb begin
    sync_d[0] = d_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    samp_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and sample flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign delta     = sync_q[SYNC_STAGES-1] ^ samp_q;

endmodule

// File: rtl/cpu_io_bank.sv
// Memory-mapped bank of N_CH I/O channels: synchronised inputs, output
// registers, sticky change flags and a maskable, registered interrupt.
module cpu_io_bank
  import cpu_io_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  WIDTH       = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int ADDR_W      = io_addr_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*WIDTH-1:0]  io_in,
  output logic [N_CH*WIDTH-1:0]  io_out,
  input  logic [ADDR_W-1:0]      csr_addr,
  input  logic                   csr_we,
  input  logic                   csr_re,
  input  logic [WIDTH-1:0]       csr_wdata,
  output logic [WIDTH-1:0]       csr_rdata,
  output logic                   irq
);

  localparam int CHAN_W = ADDR_W - 2;

  logic [CHAN_W-1:0] chan_s;
  logic [1:0]        reg_s;

  logic [WIDTH-1:0] in_s    [N_CH];
  logic [WIDTH-1:0] delta_s [N_CH];
  logic [WIDTH-1:0] w1c_s   [N_CH];

  logic [WIDTH-1:0] out_q  [N_CH];
  logic [WIDTH-1:0] out_d  [N_CH];
  logic [WIDTH-1:0] chg_q  [N_CH];
  logic [WIDTH-1:0] chg_d  [N_CH];
  logic [WIDTH-1:0] mask_q [N_CH];
  logic [WIDTH-1:0] mask_d [N_CH];

  logic [WIDTH-1:0] rd_val_s;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             irq_q;
  logic             irq_d;

  assign chan_s = csr_addr[ADDR_W-1:2];
  assign reg_s  = csr_addr[1:0];

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      io_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .d_in      (io_in[c*WIDTH +: WIDTH]),
        .sync_last (in_s[c]),
        .delta     (delta_s[c])
      );
      assign io_out[c*WIDTH +: WIDTH] = out_q[c];
    end
  endgenerate

  // CSR write decode; channel indices past N_CH never match and are dropped.
  // CHG clears written ones but a same-cycle input change wins.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      out_d[c]  = out_q[c];
      mask_d[c] = mask_q[c];
      w1c_s[c]  = '0;
      if (csr_we && (chan_s == CHAN_W'(c))) begin
        case (reg_s)
          IO_REG_OUT:  out_d[c]  = csr_wdata;
          IO_REG_CHG:  w1c_s[c]  = csr_wdata;
          IO_REG_MASK: mask_d[c] = csr_wdata;
          default:     w1c_s[c]  = '0;
        endcase
      end else begin
        w1c_s[c] = '0;
      end
      chg_d[c] = (chg_q[c] & ~w1c_s[c]) | delta_s[c];
    end
  end

  // Read mux over current (pre-write) state, registered only on read strobes;
  // irq is the OR over channels of enabled change flags.
  always_comb begin
    rd_val_s = '0;
    irq_d    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (chan_s == CHAN_W'(c)) begin
        case (reg_s)
          IO_REG_IN:   rd_val_s = in_s[c];
          IO_REG_OUT:  rd_val_s = out_q[c];
          IO_REG_CHG:  rd_val_s = chg_q[c];
          IO_REG_MASK: rd_val_s = mask_q[c];
          default:     rd_val_s = '0;
        endcase
      end else begin
        rd_val_s = rd_val_s;
      end
      irq_d = irq_d | (|(chg_q[c] & mask_q[c]));
    end
    if (csr_re) begin
      rdata_d = rd_val_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Register state; reset overrides any access in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        out_q[c]  <= '0;
        chg_q[c]  <= '0;
        mask_q[c] <= '0;
      end
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      chg_q   <= chg_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign csr_rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_cpu_io_bank.sv
// Scoreboard bench for cpu_io_bank: a 4-channel and a 3-channel instance share
// one stimulus bus and are checked against a queue-based behavioural model.
module tb_cpu_io_bank;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] io_in;
  logic [3:0]   csr_addr;
  logic         csr_we;
  logic         csr_re;
  logic [31:0]  csr_wdata;

  logic [127:0] io_out4;
  logic [31:0]  rdata4;
  logic         irq4;
  logic [95:0]  io_out3;
  logic [31:0]  rdata3;
  logic         irq3;

  always #5 clk = ~clk;

  cpu_io_bank #(.N_CH(4), .WIDTH(W), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out4),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_re(csr_re),
    .csr_wdata(csr_wdata), .csr_rdata(rdata4), .irq(irq4)
  );

  cpu_io_bank #(.N_CH(3), .WIDTH(W), .SYNC_STAGES(S)) dut3 (
    .clk(clk), .rst(rst), .io_in(io_in[95:0]), .io_out(io_out3),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_re(csr_re),
    .csr_wdata(csr_wdata), .csr_rdata(rdata3), .irq(irq3)
  );

  // Model state, index [instance][channel]; instance 0 has 4 channels, 1 has 3.
  // hist[..][0] is the io_in value seen at the latest edge, hist[..][k] k edges earlier.
  logic [31:0] m_out  [2][4];
  logic [31:0] m_chg  [2][4];
  logic [31:0] m_mask [2][4];
  logic [31:0] m_hist [2][4][S+1];
  logic        m_irq  [2];
  logic [31:0] m_rd   [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour for instance m with nch channels.
  task automatic model_step(input int m, input int nch);
    int          ch;
    logic [1:0]  r;
    logic        ok;
    logic        irq_n;
    logic [31:0] v;
    logic [31:0] w1c;
    logic [31:0] dl;
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        m_out[m][c]  = 32'd0;
        m_chg[m][c]  = 32'd0;
        m_mask[m][c] = 32'd0;
        for (int i = 0; i <= S; i++) m_hist[m][c][i] = 32'd0;
      end
      m_irq[m] = 1'b0;
      m_rd[m]  = 32'd0;
    end else begin
      ch = int'(csr_addr[3:2]);
      r  = csr_addr[1:0];
      ok = (ch < nch);
      irq_n = 1'b0;
      for (int c = 0; c < nch; c++)
        if ((m_chg[m][c] & m_mask[m][c]) != 32'd0) irq_n = 1'b1;
      if (csr_re) begin
        v = 32'd0;
        if (ok) begin
          case (r)
            2'd0: v = m_hist[m][ch][S-1];
            2'd1: v = m_out[m][ch];
            2'd2: v = m_chg[m][ch];
            default: v = m_mask[m][ch];
          endcase
        end
        m_rd[m] = v;
        if (m == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
      end
      for (int c = 0; c < nch; c++) begin
        dl  = m_hist[m][c][S-1] ^ m_hist[m][c][S];
        w1c = (csr_we && ok && ch == c && r == 2'd2) ? csr_wdata : 32'd0;
        m_chg[m][c] = (m_chg[m][c] & ~w1c) | dl;
      end
      if (csr_we && ok && r == 2'd1) m_out[m][ch]  = csr_wdata;
      if (csr_we && ok && r == 2'd3) m_mask[m][ch] = csr_wdata;
      for (int c = 0; c < nch; c++) begin
        for (int i = S; i > 0; i--) m_hist[m][c][i] = m_hist[m][c][i-1];
        m_hist[m][c][0] = io_in[c*32 +: 32];
      end
      m_irq[m] = irq_n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 3);
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic op(input logic we, input logic re, input logic [3:0] a, input logic [31:0] d);
    csr_we    = we;
    csr_re    = re;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we = 1'b0;
    csr_re = 1'b0;
  endtask

  function automatic logic [3:0] ad(input int ch, input int r);
    logic [3:0] a;
    a = {ch[1:0], r[1:0]};
    return a;
  endfunction

  // Monitor: compares outputs against the model every cycle and pops read results.
  initial begin
    logic [127:0] e4;
    logic [95:0]  e3;
    logic [31:0]  v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < 4; c++) e4[c*32 +: 32] = m_out[0][c];
        for (int c = 0; c < 3; c++) e3[c*32 +: 32] = m_out[1][c];
        chk("io_out4", io_out4, e4);
        chk("io_out3", {32'd0, io_out3}, {32'd0, e3});
        chk("irq4", {127'd0, irq4}, {127'd0, m_irq[0]});
        chk("irq3", {127'd0, irq3}, {127'd0, m_irq[1]});
        if (exp_q0.size() > 0) begin
          v = exp_q0.pop_front();
          chk("rdata4", {96'd0, rdata4}, {96'd0, v});
        end else begin
          chk("rdata4_hold", {96'd0, rdata4}, {96'd0, m_rd[0]});
        end
        if (exp_q1.size() > 0) begin
          v = exp_q1.pop_front();
          chk("rdata3", {96'd0, rdata3}, {96'd0, v});
        end else begin
          chk("rdata3_hold", {96'd0, rdata3}, {96'd0, m_rd[1]});
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; io_in = '1; csr_addr = 4'd0; csr_we = 1'b0; csr_re = 1'b0; csr_wdata = 32'd0;
    @(negedge clk);
    // Reset with all-ones inputs, then the release raises CHG everywhere.
    repeat (3) tick();
    rst = 1'b0;
    repeat (S + 2) tick();
    op(1'b0, 1'b1, ad(0, 2), 32'd0);
    op(1'b0, 1'b1, ad(3, 2), 32'd0);
    io_in = '0;
    repeat (S + 2) tick();
    for (int c = 0; c < 4; c++) op(1'b1, 1'b0, ad(c, 2), 32'hFFFF_FFFF);
    // Input latency on ch0.
    io_in[31:0] = 32'd42;
    for (int i = 0; i < S + 1; i++) op(1'b0, 1'b1, ad(0, 0), 32'd0);
    op(1'b0, 1'b1, ad(0, 2), 32'd0);
    // Masked interrupt on ch1 bit0, clear, then unmasked bit1.
    op(1'b1, 1'b0, ad(1, 3), 32'h1);
    io_in[32] = ~io_in[32];
    repeat (S + 2) tick();
    op(1'b1, 1'b0, ad(1, 2), 32'h1);
    repeat (2) tick();
    io_in[33] = ~io_in[33];
    repeat (S + 3) tick();
    op(1'b1, 1'b0, ad(1, 2), 32'h2);
    // W1C lands on the same edge the change flag sets.
    io_in[32] = ~io_in[32];
    repeat (S) tick();
    op(1'b1, 1'b0, ad(1, 2), 32'h1);
    op(1'b0, 1'b1, ad(1, 2), 32'd0);
    tick();
    // OUT write, readback, IN write ignored.
    op(1'b1, 1'b0, ad(3, 1), 32'hDEAD_BEEF);
    op(1'b0, 1'b1, ad(3, 1), 32'd0);
    op(1'b1, 1'b0, ad(0, 0), 32'h1234_5678);
    op(1'b0, 1'b1, ad(0, 0), 32'd0);
    // Same-cycle write/read returns the old value; ch3 absent in the 3-ch bank.
    op(1'b1, 1'b1, ad(2, 1), 32'hCAFE_F00D);
    op(1'b0, 1'b1, ad(2, 1), 32'd0);
    op(1'b1, 1'b0, ad(3, 3), 32'hFFFF_FFFF);
    op(1'b0, 1'b1, ad(3, 3), 32'd0);
    op(1'b0, 1'b1, ad(3, 0), 32'd0);
    // Randomized traffic with one mid-operation reset.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) io_in[$urandom_range(0, 127)] = ~io_in[$urandom_range(0, 127)];
      if (n == 400) rst = 1'b1;
      op(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
         4'($urandom_range(0, 15)),
         ($urandom_range(0, 1) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'($urandom));
      rst = 1'b0;
    end
    repeat (S + 3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
